// File: rtl/switch_pkg.sv
// Shared constants for the two-channel switch debouncer.
// Edge pulses are built only when SWITCH_DEBOUNCE_EDGE_EN is defined.
package switch_pkg;

    localparam int STABLE_CYCLES_DEF = 16;
    localparam int CNT_W_DEF         = 16;
    localparam int NUM_CH            = 2;

endpackage : switch_pkg

// File: rtl/switch_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, accepted level
// and optional edge pulses (compiled in with SWITCH_DEBOUNCE_EDGE_EN).
module debounce_ch
    import switch_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A mismatch must survive STABLE_CYCLES consecutive cycles; any match restarts it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    // Pulses are registered on the same edge that updates stable, so they line up with level_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= stable_d & ~stable_q;
            fall_q <= ~stable_d & stable_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule : debounce_ch

// File: rtl/switch_debounce.sv
// Two-channel switch debouncer top: one debounce_ch per raw switch, wiring only.
// Edge pulse ports read 0 unless SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    logic [NUM_CH-1:0] raw_w;
    logic [NUM_CH-1:0] level_w;
    logic [NUM_CH-1:0] rise_w;
    logic [NUM_CH-1:0] fall_w;

    // Channel 0 is A, channel 1 is B.
    assign raw_w = {b_raw, a_raw};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (raw_w[ch]),
            .level_o (level_w[ch]),
            .rise_o  (rise_w[ch]),
            .fall_o  (fall_w[ch])
        );
    end

    assign a      = level_w[0];
    assign b      = level_w[1];
    assign a_rise = rise_w[0];
    assign a_fall = fall_w[0];
    assign b_rise = rise_w[1];
    assign b_fall = fall_w[1];

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with STABLE_CYCLES=4; pulse expectations
// follow SWITCH_DEBOUNCE_EDGE_EN (forced to 0 when the macro is undefined).
module tb_switch_debounce;

    localparam int SC = 4;
    localparam int W  = 6;   // {a, b, a_rise, a_fall, b_rise, b_fall}

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a, b, a_rise, a_fall, b_rise, b_fall;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    string tag = "init";

    switch_debounce #(
        .STABLE_CYCLES (SC),
        .CNT_W         (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a      (a),
        .b      (b),
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pv(input logic ea, input logic eb, input logic ear,
                                        input logic eaf, input logic ebr, input logic ebf);
        return {ea, eb, ear & EDGE, eaf & EDGE, ebr & EDGE, ebf & EDGE};
    endfunction

    task automatic push(input int n, input logic [W-1:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic check_now();
        logic [W-1:0] obs;
        logic [W-1:0] expv;
        obs = {a, b, a_rise, a_fall, b_rise, b_fall};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", tag, obs, expv);
            end
        end
    endtask

    // One comparison per rising edge, sampled 1 time unit after the edge.
    task automatic drain();
        int budget;
        budget = exp_q.size();
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            check_now();
        end
    endtask

    initial begin
        // Reset with A already high, then release: full latency plus rise pulse.
        tag = "reset_state";
        a_raw = 1'b1;
        b_raw = 1'b0;
        rst_n = 1'b0;
        #23;
        push(1, pv(0, 0, 0, 0, 0, 0));
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tag = "rise_after_reset";
        push(SC + 1, pv(0, 0, 0, 0, 0, 0));
        push(1, pv(1, 0, 1, 0, 0, 0));
        push(2, pv(1, 0, 0, 0, 0, 0));
        drain();

        tag = "a_fall";
        a_raw = 1'b0;
        push(SC + 1, pv(1, 0, 0, 0, 0, 0));
        push(1, pv(0, 0, 0, 1, 0, 0));
        push(2, pv(0, 0, 0, 0, 0, 0));
        drain();

        // Three-cycle glitch is shorter than STABLE_CYCLES and must be ignored.
        tag = "glitch";
        a_raw = 1'b1;
        push(3, pv(0, 0, 0, 0, 0, 0));
        drain();
        a_raw = 1'b0;
        push(10, pv(0, 0, 0, 0, 0, 0));
        drain();

        // Full latency afterwards shows the partial count was discarded.
        tag = "a_rise_held";
        a_raw = 1'b1;
        push(SC + 1, pv(0, 0, 0, 0, 0, 0));
        push(1, pv(1, 0, 1, 0, 0, 0));
        push(3, pv(1, 0, 0, 0, 0, 0));
        drain();

        tag = "a_fall2";
        a_raw = 1'b0;
        push(SC + 1, pv(1, 0, 0, 0, 0, 0));
        push(1, pv(0, 0, 0, 1, 0, 0));
        push(2, pv(0, 0, 0, 0, 0, 0));
        drain();

        tag = "b_only";
        b_raw = 1'b1;
        push(SC + 1, pv(0, 0, 0, 0, 0, 0));
        push(1, pv(0, 1, 0, 0, 1, 0));
        push(2, pv(0, 1, 0, 0, 0, 0));
        drain();
        b_raw = 1'b0;
        push(SC + 1, pv(0, 1, 0, 0, 0, 0));
        push(1, pv(0, 0, 0, 0, 0, 1));
        push(2, pv(0, 0, 0, 0, 0, 0));
        drain();

        tag = "both_rise";
        a_raw = 1'b1;
        b_raw = 1'b1;
        push(SC + 1, pv(0, 0, 0, 0, 0, 0));
        push(1, pv(1, 1, 1, 0, 1, 0));
        push(2, pv(1, 1, 0, 0, 0, 0));
        drain();

        tag = "both_fall";
        a_raw = 1'b0;
        b_raw = 1'b0;
        push(SC + 1, pv(1, 1, 0, 0, 0, 0));
        push(1, pv(0, 0, 0, 1, 0, 1));
        push(2, pv(0, 0, 0, 0, 0, 0));
        drain();

        // Reset when the counter has reached 2 of a 0->1 change.
        tag = "pre_reset_count";
        a_raw = 1'b1;
        push(4, pv(0, 0, 0, 0, 0, 0));
        drain();
        tag = "mid_count_reset";
        rst_n = 1'b0;
        #1;
        push(1, pv(0, 0, 0, 0, 0, 0));
        check_now();
        push(2, pv(0, 0, 0, 0, 0, 0));
        drain();
        rst_n = 1'b1;
        tag = "restart_latency";
        push(SC + 1, pv(0, 0, 0, 0, 0, 0));
        push(1, pv(1, 0, 1, 0, 0, 0));
        push(2, pv(1, 0, 0, 0, 0, 0));
        drain();

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL leftover: %0d expected entries never compared, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_switch_debounce
